chunked_adder: RTL and testbench
================================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 40, meaning the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning the bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and N = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-007 The block SHALL have ports A and B, input, WIDTH bits each: unsigned operands.
REQ-008 The block SHALL have port C_in, input, 1 bit: carry into bit 0.
REQ-009 The block SHALL have port busy, output, 1 bit: an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 The block SHALL have port S, output, WIDTH bits: registered sum.
REQ-012 The block SHALL have port C_out, output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture A, B and C_in into internal registers, clear the chunk index to 0 and enter RUN.
REQ-015 start SHALL be ignored in RUN; the captured operands SHALL NOT change while in RUN.
REQ-016 Each RUN cycle SHALL compute captured_A[chunk] + captured_B[chunk] + carry, store the CHUNK-bit sum into the matching chunk of the internal sum, register the carry for the next chunk and increment the chunk index; chunk 0 SHALL use captured C_in.
REQ-017 After exactly N RUN cycles, the block SHALL enter DONE and load S and C_out on the same edge.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle per accepted start; done SHALL rise N+1 edges after the edge that sampled start.
REQ-019 busy SHALL be 1 exactly when the state is RUN.
REQ-020 DONE with start=0 SHALL return to IDLE; DONE with start=1 SHALL re-enter RUN, giving a back-to-back throughput of one result per N+1 cycles.
REQ-021 S and C_out SHALL hold their values from the last DONE until the next DONE; the result SHALL equal (A + B + C_in) mod 2^(WIDTH+1) split as {C_out, S}.
REQ-022 The CHUNK = WIDTH case (N=1) SHALL work with a latency of 2 edges.

Reset
REQ-023 rst=1 at a rising edge SHALL set the state to IDLE and busy, done, S and C_out to 0, and clear the chunk index, carry and captured operands; rst SHALL take priority over start.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; start=1 in the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-025 With macro CHUNKED_ADDER_SIGNED_OVF_EN defined, the block SHALL add output V, 1 bit, reset 0, loaded with S on DONE; V SHALL be 1 when captured A and B have equal MSBs that differ from the MSB of S (two's-complement overflow).
REQ-026 Without CHUNKED_ADDER_SIGNED_OVF_EN, port V and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=40, CHUNK=8, N=5)
REQ-027 Basic add: A=11, B=1111, C_in=0, start pulse -> done 6 edges later, S=1122, C_out=0, busy high for 5 cycles.
REQ-028 Full carry chain: A=B=all-ones, C_in=1 -> S=all-ones (0xFF_FFFF_FFFF), C_out=1.
REQ-029 Carry without C_in: A=B=all-ones, C_in=0 -> S=0xFF_FFFF_FFFE, C_out=1; next, start held high in DONE with A=1, B=2 -> second done 6 edges later, S=3.
REQ-030 Start while busy: pulse start with A=5 and B=5 at RUN cycle 2 of an 11+1111 add -> single done, S=1122, and no additional done follows.
REQ-031 Reset mid-operation: assert rst in RUN cycle 3 -> no done, and S, C_out, busy, done are all 0; a new start with A=7, B=8 then yields S=15.
REQ-032 With CHUNKED_ADDER_SIGNED_OVF_EN: A=0x7F_FFFF_FFFF, B=1, C_in=0 -> S=0x80_0000_0000, V=1, C_out=0; A=B=all-ones -> V=0.

Source files
------------

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder, CHUNK bits per clock, N = WIDTH/CHUNK.
// Optional signed overflow flag V when CHUNKED_ADDER_SIGNED_OVF_EN is defined.
module chunked_adder #(
  parameter int WIDTH = 40,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last;

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  // Select the active chunk and add it with the running carry
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk}
              + {{CHUNK{1'b0}}, carry_q};
    last = (idx_q == IW'(N - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, chunk accumulation and result load
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IW'(i)) begin
          sum_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        end
      end
      carry_d = chunk_sum[CHUNK];
      idx_d   = last ? '0 : idx_q + IW'(1);
      if (last) begin
        s_d    = sum_d;
        cout_d = chunk_sum[CHUNK];
        v_d    = (a_q[WIDTH-1] == b_q[WIDTH-1])
              && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end else if (start) begin
      a_d     = A;
      b_d     = B;
      carry_d = C_in;
      idx_d   = '0;
      sum_d   = '0;
    end
  end

  // Outputs decoded from state and result registers
  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    S     = s_q;
    C_out = cout_q;
  end

`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
  assign V = v_q;
`else
  logic unused_v;
  assign unused_v = v_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and random checks of chunked_adder against
// an arithmetic reference model (N=5 instance plus an N=1 instance).
module tb_chunked_adder;

  localparam int W  = 40;
  localparam int N  = 5;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] s;
  logic         v;

  logic         start1;
  logic [7:0]   a1, b1, s1;
  logic         c1, busy1, done1, cout1, v1;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(a), .B(b), .C_in(cin),
    .busy(busy), .done(done), .S(s), .C_out(cout)
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    , .V(v)
`endif
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .A(a1), .B(b1), .C_in(c1),
    .busy(busy1), .done(done1), .S(s1), .C_out(cout1)
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    , .V(v1)
`endif
  );

`ifndef CHUNKED_ADDER_SIGNED_OVF_EN
  assign v  = 1'b0;
  assign v1 = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; inputs presented for the next edge.
  task automatic launch(input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic c);
    start = 1'b1;
    a = x;
    b = y;
    cin = c;
  endtask

  // Counts edges from the sampling edge (counted as 1) until done.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done) break;
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag,
                              input logic [W-1:0] x,
                              input logic [W-1:0] y,
                              input logic c,
                              input int lat,
                              input int bcnt);
    logic [W:0] ref_sum;
    longint sx, sy, ss;
    logic ref_v;
    ref_sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ss = sx + sy + longint'(c);
    ref_v = (ss > 64'sd549755813887) || (ss < -64'sd549755813888);
    chk({tag, "_lat"}, 64'(lat), 64'(N + 1));
    chk({tag, "_busy"}, 64'(bcnt), 64'(N));
    chk({tag, "_S"}, 64'(s), 64'(ref_sum[W-1:0]));
    chk({tag, "_Cout"}, 64'(cout), 64'(ref_sum[W]));
`ifdef CHUNKED_ADDER_SIGNED_OVF_EN
    chk({tag, "_V"}, 64'(v), 64'(ref_v));
`endif
  endtask

  task automatic check_hold(input string tag);
    logic [W-1:0] s_prev;
    logic c_prev;
    s_prev = s;
    c_prev = cout;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_donepulse"}, 64'(done), 64'(0));
    chk({tag, "_Shold"}, 64'(s), 64'(s_prev));
    chk({tag, "_Chold"}, 64'(cout), 64'(c_prev));
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [63:0] r0, r1;
    logic [W-1:0] x, y;
    logic c;
    logic [8:0] ref1;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    start1 = 1'b0;
    a1 = '0;
    b1 = '0;
    c1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_S", 64'(s), 64'(0));
    chk("rst_Cout", 64'(cout), 64'(0));
    chk("rst_V", 64'(v), 64'(0));
    chk("rst1_S", 64'(s1), 64'(0));

    // basic add
    launch(40'd11, 40'd1111, 1'b0);
    wait_done(lat, bcnt);
    check_result("basic", 40'd11, 40'd1111, 1'b0, lat, bcnt);
    check_hold("basic");

    // full carry chain with C_in
    launch(ONES, ONES, 1'b1);
    wait_done(lat, bcnt);
    check_result("chain", ONES, ONES, 1'b1, lat, bcnt);
    check_hold("chain");

    // carry without C_in, then back-to-back start held in DONE
    launch(ONES, ONES, 1'b0);
    wait_done(lat, bcnt);
    check_result("b2b_a", ONES, ONES, 1'b0, lat, bcnt);
    launch(40'd1, 40'd2, 1'b0);
    wait_done(lat, bcnt);
    check_result("b2b_b", 40'd1, 40'd2, 1'b0, lat, bcnt);
    check_hold("b2b_b");

    // start pulsed while busy is ignored
    launch(40'd11, 40'd1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    launch(40'd5, 40'd5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin
          chk("busystart_S", 64'(s), 64'd1122);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("busystart_ndone", 64'(dcnt), 64'(1));

    // reset during RUN aborts the operation
    launch(40'd11, 40'd1111, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_inrun", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_S", 64'(s), 64'(0));
    chk("abort_Cout", 64'(cout), 64'(0));
    launch(40'd7, 40'd8, 1'b0);
    wait_done(lat, bcnt);
    check_result("abort_new", 40'd7, 40'd8, 1'b0, lat, bcnt);

    // signed overflow vectors
    launch(40'h7F_FFFF_FFFF, 40'd1, 1'b0);
    wait_done(lat, bcnt);
    check_result("ovf", 40'h7F_FFFF_FFFF, 40'd1, 1'b0, lat, bcnt);
    launch(40'h80_0000_0000, 40'h80_0000_0000, 1'b1);
    wait_done(lat, bcnt);
    check_result("ovfneg", 40'h80_0000_0000, 40'h80_0000_0000,
                 1'b1, lat, bcnt);
    check_hold("ovfneg");

    // random operands, mixing in edge patterns
    for (int t = 0; t < 24; t++) begin
      r0 = {$urandom(), $urandom()};
      r1 = {$urandom(), $urandom()};
      x = r0[W-1:0];
      y = r1[W-1:0];
      c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) x = ONES;
      if ($urandom_range(0, 5) == 0) y = '0;
      launch(x, y, c);
      wait_done(lat, bcnt);
      check_result("rand", x, y, c, lat, bcnt);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    // single-chunk instance: two-edge latency
    for (int t = 0; t < 6; t++) begin
      a1 = 8'($urandom());
      b1 = 8'($urandom());
      c1 = 1'($urandom_range(0, 1));
      if (t == 0) begin
        a1 = 8'hFF;
        b1 = 8'hFF;
        c1 = 1'b1;
      end
      ref1 = {1'b0, a1} + {1'b0, b1} + {8'd0, c1};
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("n1_busy", 64'(busy1), 64'(1));
      chk("n1_early", 64'(done1), 64'(0));
      @(posedge clk);
      @(negedge clk);
      chk("n1_done", 64'(done1), 64'(1));
      chk("n1_S", 64'(s1), 64'(ref1[7:0]));
      chk("n1_Cout", 64'(cout1), 64'(ref1[8]));
      @(posedge clk);
      @(negedge clk);
      chk("n1_pulse", 64'(done1), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
